imem_boot_arb: RTL and testbench

Boot-loader and port arbiter for the single-port instruction memory behind the fetch stage. After reset it streams a program image into IMEM while holding the core in reset. It then releases the core and shares the IMEM port between the fetch stage and a debug read port. Fetch has priority; a starvation counter guarantees debug forward progress. The block sits between the fetch stage's PC/IMEM address path and IMEM, and drives the fetch write-enable gating.

---
 rtl/imem_boot_arb.sv | 111 +++++++++++
 tb/tb_imem_boot_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_arb.sv
// rtl/imem_boot_arb.sv - IMEM boot loader and fetch/debug port arbiter
// Streams a program image into IMEM under core reset, then arbitrates fetch vs. debug reads.
module imem_boot_arb #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  input  logic                  reload,
  output logic                  core_reset,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_req,
  output logic                  fetch_stall,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [31:0]           dbg_rdata,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic [31:0]           imem_rdata,
  output logic [ADDR_WIDTH:0]   load_count
);

  typedef enum logic [1:0] {LOAD, SETTLE, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [3:0]            LIMIT     = 4'(STARVE_LIMIT);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [3:0]            starve_cnt;
  logic                  rvalid_q;
  logic                  ld_fire;

  always_comb begin
    ld_ready    = 1'b0;
    core_reset  = 1'b1;
    fetch_stall = 1'b1;
    dbg_gnt     = 1'b0;
    imem_we     = 1'b0;
    imem_addr   = '0;
    imem_wdata  = ld_data;
    if (!reset) begin
      case (state)
        LOAD: begin
          ld_ready  = 1'b1;
          imem_we   = ld_valid;
          imem_addr = wr_ptr;
        end
        SETTLE: imem_addr = wr_ptr;
        RUN: begin
          core_reset  = 1'b0;
          dbg_gnt     = dbg_req && (!fetch_req || starve_cnt == LIMIT);
          fetch_stall = dbg_gnt;
          imem_addr   = dbg_gnt ? dbg_addr : fetch_addr;
        end
        default: imem_addr = '0;
      endcase
    end
  end

  assign ld_fire    = ld_ready && ld_valid;
  // Read data path stays purely combinational so no control output ever depends on it.
  assign dbg_rdata  = imem_rdata;
  assign dbg_rvalid = rvalid_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      load_count <= '0;
      starve_cnt <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= dbg_gnt;
      case (state)
        LOAD: begin
          if (ld_fire) begin
            load_count <= load_count + CNT_ONE;
            // The pointer parks at the top address; a full memory ends the load by itself.
            if (wr_ptr != LAST_ADDR) wr_ptr <= wr_ptr + PTR_ONE;
            if (ld_last || wr_ptr == LAST_ADDR) state <= SETTLE;
          end
        end
        SETTLE: state <= RUN;
        RUN: begin
          if (reload) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            load_count <= '0;
            starve_cnt <= '0;
          end else if (dbg_req && !dbg_gnt) begin
            if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_arb.sv
// tb/tb_imem_boot_arb.sv - self-checking bench for imem_boot_arb
// Small IMEM model plus a golden image array; arbitration checked against a starvation model.
module tb_imem_boot_arb;
  localparam int AW = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset, ld_valid, ld_ready, ld_last, reload, core_reset;
  logic [31:0]   ld_data, dbg_rdata, imem_wdata, imem_rdata;
  logic [AW-1:0] fetch_addr, dbg_addr, imem_addr;
  logic          fetch_req, fetch_stall, dbg_req, dbg_gnt, dbg_rvalid, imem_we;
  logic [AW:0]   load_count;

  logic [31:0] mem    [16];
  logic [31:0] golden [16];
  logic [31:0] img    [16];
  int tests_run = 0;
  int tests_failed = 0;

  imem_boot_arb #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .reload(reload), .core_reset(core_reset), .fetch_addr(fetch_addr),
    .fetch_req(fetch_req), .fetch_stall(fetch_stall), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata <= mem[imem_addr];
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end

  // Inputs change 2 time units after the edge; outputs are sampled 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle_outputs();
    #2;
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_data = 0; ld_last = 0; reload = 0;
    fetch_req = 0; fetch_addr = 0; dbg_req = 0; dbg_addr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; ld_valid = 1; fetch_req = 1; dbg_req = 1;
    #2;
    for (int k = 0; k < 2; k++) begin
      tests_run++; if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ld_ready got %b exp 0", ld_ready); end
      tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL rst_core_reset got %b exp 1", core_reset); end
      tests_run++; if (fetch_stall !== 1'b1) begin tests_failed++; $display("FAIL rst_fetch_stall got %b exp 1", fetch_stall); end
      tests_run++; if (imem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_imem_we got %b exp 0", imem_we); end
      tests_run++; if (dbg_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_dbg_gnt got %b exp 0", dbg_gnt); end
      tests_run++; if (dbg_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_dbg_rvalid got %b exp 0", dbg_rvalid); end
      tests_run++; if (imem_addr !== 4'd0) begin tests_failed++; $display("FAIL rst_imem_addr got %0h exp 0", imem_addr); end
      next_cycle();
    end
    tests_run++; if (load_count !== 5'd0) begin tests_failed++; $display("FAIL rst_load_count got %0d exp 0", load_count); end
    reset = 0; idle_inputs();
    settle_outputs();
    tests_run++; if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_ld_ready got %b exp 1", ld_ready); end
    tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL post_rst_core_reset got %b exp 1", core_reset); end
  endtask

  task automatic test_load3();
    logic [31:0] w [3];
    w[0] = 32'h00000013; w[1] = 32'h00100093; w[2] = 32'h00200113;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = w[i]; ld_last = (i == 2);
      settle_outputs();
      tests_run++; if (imem_we !== 1'b1 || imem_addr !== 4'(i)) begin tests_failed++; $display("FAIL load3_write[%0d] got we=%b addr=%0d exp we=1 addr=%0d", i, imem_we, imem_addr, i); end
      golden[i] = w[i];
      next_cycle();
    end
    idle_inputs();
    settle_outputs();
    tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL load3_settle_core_reset got %b exp 1", core_reset); end
    tests_run++; if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL load3_settle_ld_ready got %b exp 0", ld_ready); end
    tests_run++; if (load_count !== 5'd3) begin tests_failed++; $display("FAIL load3_count got %0d exp 3", load_count); end
    next_cycle();
    settle_outputs();
    tests_run++; if (core_reset !== 1'b0) begin tests_failed++; $display("FAIL load3_run_core_reset got %b exp 0", core_reset); end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (mem[i] !== w[i]) begin tests_failed++; $display("FAIL load3_mem[%0d] got %h exp %h", i, mem[i], w[i]); end
    end
  endtask

  task automatic test_dbg_idle();
    next_cycle();
    fetch_req = 0; dbg_req = 1; dbg_addr = 2;
    settle_outputs();
    tests_run++; if (dbg_gnt !== 1'b1) begin tests_failed++; $display("FAIL dbg_idle_gnt got %b exp 1", dbg_gnt); end
    tests_run++; if (imem_addr !== 4'd2) begin tests_failed++; $display("FAIL dbg_idle_addr got %0d exp 2", imem_addr); end
    next_cycle();
    dbg_req = 0;
    settle_outputs();
    tests_run++; if (dbg_rvalid !== 1'b1) begin tests_failed++; $display("FAIL dbg_idle_rvalid got %b exp 1", dbg_rvalid); end
    tests_run++; if (dbg_rdata !== 32'h00200113) begin tests_failed++; $display("FAIL dbg_idle_rdata got %h exp 00200113", dbg_rdata); end
  endtask

  task automatic test_starve();
    next_cycle();
    idle_inputs();
    next_cycle();
    fetch_req = 1; fetch_addr = 5; dbg_req = 1; dbg_addr = 1;
    for (int k = 0; k <= SL; k++) begin
      settle_outputs();
      tests_run++; if (dbg_gnt !== (k == SL)) begin tests_failed++; $display("FAIL starve_gnt[t+%0d] got %b exp %b", k, dbg_gnt, (k == SL)); end
      tests_run++; if (fetch_stall !== (k == SL)) begin tests_failed++; $display("FAIL starve_stall[t+%0d] got %b exp %b", k, fetch_stall, (k == SL)); end
      tests_run++; if (imem_addr !== ((k == SL) ? 4'd1 : 4'd5)) begin tests_failed++; $display("FAIL starve_addr[t+%0d] got %0d", k, imem_addr); end
      next_cycle();
    end
    dbg_req = 0;
    settle_outputs();
    tests_run++; if (fetch_stall !== 1'b0) begin tests_failed++; $display("FAIL starve_release_stall got %b exp 0", fetch_stall); end
    tests_run++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== golden[1]) begin tests_failed++; $display("FAIL starve_rdata got v=%b d=%h exp v=1 d=%h", dbg_rvalid, dbg_rdata, golden[1]); end
  endtask

  task automatic test_reload_dbg();
    next_cycle();
    idle_inputs();
    dbg_req = 1; dbg_addr = 0; reload = 1;
    settle_outputs();
    tests_run++; if (dbg_gnt !== 1'b1) begin tests_failed++; $display("FAIL reload_gnt got %b exp 1", dbg_gnt); end
    next_cycle();
    idle_inputs();
    settle_outputs();
    tests_run++; if (dbg_rvalid !== 1'b1) begin tests_failed++; $display("FAIL reload_rvalid got %b exp 1", dbg_rvalid); end
    tests_run++; if (core_reset !== 1'b1 || ld_ready !== 1'b1) begin tests_failed++; $display("FAIL reload_state got core_reset=%b ld_ready=%b exp 1 1", core_reset, ld_ready); end
    tests_run++; if (load_count !== 5'd0) begin tests_failed++; $display("FAIL reload_count got %0d exp 0", load_count); end
    next_cycle();
    ld_valid = 1; ld_data = img[0];
    settle_outputs();
    tests_run++; if (imem_we !== 1'b1 || imem_addr !== 4'd0) begin tests_failed++; $display("FAIL reload_first_write got we=%b addr=%0d exp we=1 addr=0", imem_we, imem_addr); end
    golden[0] = img[0];
    next_cycle();
  endtask

  // Continues the image whose word 0 went in during the reload test.
  task automatic test_full_load();
    int zero_writes = 0;
    for (int i = 1; i < 16; i++) begin
      ld_valid = 1; ld_data = img[i]; ld_last = 0;
      settle_outputs();
      tests_run++; if (ld_ready !== 1'b1 || imem_we !== 1'b1 || imem_addr !== 4'(i)) begin tests_failed++; $display("FAIL full_write[%0d] got rdy=%b we=%b addr=%0d", i, ld_ready, imem_we, imem_addr); end
      golden[i] = img[i];
      next_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      ld_valid = 1; ld_data = 32'hdeadbeef;
      settle_outputs();
      if (imem_we && imem_addr == 4'd0) zero_writes++;
      tests_run++; if (ld_ready !== 1'b0 || imem_we !== 1'b0) begin tests_failed++; $display("FAIL full_after[%0d] got rdy=%b we=%b exp 0 0", k, ld_ready, imem_we); end
      tests_run++; if (core_reset !== (k == 0)) begin tests_failed++; $display("FAIL full_core_reset[%0d] got %b exp %b", k, core_reset, (k == 0)); end
      next_cycle();
    end
    idle_inputs();
    tests_run++; if (zero_writes != 0) begin tests_failed++; $display("FAIL full_addr0_rewrite got %0d exp 0", zero_writes); end
    tests_run++; if (load_count !== 5'd16) begin tests_failed++; $display("FAIL full_count got %0d exp 16", load_count); end
    for (int i = 0; i < 16; i++) begin
      tests_run++; if (mem[i] !== golden[i]) begin tests_failed++; $display("FAIL full_mem[%0d] got %h exp %h", i, mem[i], golden[i]); end
    end
  endtask

  // Model: debug waits behind fetch, but never more than SL denied cycles in a row.
  task automatic test_random_arb();
    int denied = 0;
    int wait_len = 0;
    logic prev_gnt = 0;
    logic [AW-1:0] prev_addr = 0;
    logic exp_gnt;
    for (int c = 0; c < 300; c++) begin
      fetch_req = ($urandom_range(0, 3) != 0);
      fetch_addr = AW'($urandom_range(0, 15));
      if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1; dbg_addr = AW'($urandom_range(0, 15)); wait_len = 0;
      end
      settle_outputs();
      exp_gnt = dbg_req && (!fetch_req || denied >= SL);
      tests_run++; if (dbg_gnt !== exp_gnt || fetch_stall !== exp_gnt) begin tests_failed++; $display("FAIL rand_gnt[%0d] got gnt=%b stall=%b exp %b", c, dbg_gnt, fetch_stall, exp_gnt); end
      tests_run++; if (imem_addr !== (exp_gnt ? dbg_addr : fetch_addr) || imem_we !== 1'b0 || core_reset !== 1'b0) begin tests_failed++; $display("FAIL rand_port[%0d] got addr=%0d we=%b cr=%b", c, imem_addr, imem_we, core_reset); end
      tests_run++; if (dbg_rvalid !== prev_gnt || (prev_gnt && dbg_rdata !== golden[prev_addr])) begin tests_failed++; $display("FAIL rand_rdata[%0d] got v=%b d=%h exp v=%b d=%h", c, dbg_rvalid, dbg_rdata, prev_gnt, golden[prev_addr]); end
      if (dbg_req) wait_len++;
      if (dbg_gnt) begin
        tests_run++; if (wait_len > SL + 1) begin tests_failed++; $display("FAIL rand_latency[%0d] got %0d exp <= %0d", c, wait_len, SL + 1); end
      end
      denied = (dbg_req && !exp_gnt) ? denied + 1 : 0;
      prev_gnt = exp_gnt; prev_addr = dbg_addr;
      next_cycle();
      if (prev_gnt) dbg_req = 0;
    end
    idle_inputs();
  endtask

  task automatic test_reset_midload();
    reload = 1;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_data = 32'h1000 + 32'(i);
      next_cycle();
    end
    reset = 1; ld_valid = 1; dbg_req = 1; fetch_req = 0;
    settle_outputs();
    tests_run++; if (ld_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 4'd0) begin tests_failed++; $display("FAIL midrst_load got rdy=%b we=%b addr=%0d exp 0 0 0", ld_ready, imem_we, imem_addr); end
    tests_run++; if (core_reset !== 1'b1 || fetch_stall !== 1'b1 || dbg_gnt !== 1'b0 || dbg_rvalid !== 1'b0) begin tests_failed++; $display("FAIL midrst_ctrl got cr=%b fs=%b gnt=%b rv=%b", core_reset, fetch_stall, dbg_gnt, dbg_rvalid); end
    next_cycle();
    reset = 0; idle_inputs();
    ld_valid = 1; ld_data = 32'h55aa55aa;
    settle_outputs();
    tests_run++; if (imem_we !== 1'b1 || imem_addr !== 4'd0) begin tests_failed++; $display("FAIL midrst_first_write got we=%b addr=%0d exp 1 0", imem_we, imem_addr); end
    next_cycle();
    ld_valid = 0;
    settle_outputs();
    tests_run++; if (load_count !== 5'd1) begin tests_failed++; $display("FAIL midrst_count got %0d exp 1", load_count); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0; golden[i] = 32'h0; img[i] = $urandom;
    end
    idle_inputs();
    reset = 1;
    test_reset();
    test_load3();
    test_dbg_idle();
    test_starve();
    test_reload_dbg();
    test_full_load();
    test_random_arb();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
